led_frame_streamer: RTL and testbench

- Sits between the RAM bank and the ws2812 bit encoder, in the clk_sb domain.
- On a start pulse it walks the RAM bank as one linear byte space and packs every 3 bytes into a 24-bit GRB word.
- It presents each word to the encoder on the new_data_req handshake and holds send_leds_n low for the whole frame.
- It owns the RAM read port while busy=1; the top-level muxes addr/sel toward sb_translator when busy=0.

---
 rtl/led_frame_streamer_if.sv | 33 +++
 rtl/led_frame_streamer.sv | 226 ++++++++++++++++++++++
 tb/tb_led_frame_streamer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_streamer_if.sv
// led_frame_streamer_if
//   Bundles the RAM read port and the ws2812 encoder handshake used by
//   led_frame_streamer.
//   master : streamer side (drives address/select and the encoder word)
//   slave  : RAM bank + encoder side
//   Signals:
//     addr_out     RAM read address (byte offset inside a 512x8 block)
//     ram_sel      one-hot RAM block select, all-zero when not reading
//     ram_data_in  selected RAM dout, valid one cycle after addr/sel
//     new_data_req one-cycle pulse from the encoder: word latched, send next
//     rgb_data_out {G,R,B} word presented to the encoder
//     send_leds_n  active-low frame enable to the encoder
interface led_frame_streamer_if #(
  parameter int unsigned NUM_MEM_BLOCKS = 14,
  parameter int unsigned ADDR_W         = 9
);
  logic [ADDR_W-1:0]         addr_out;
  logic [NUM_MEM_BLOCKS-1:0] ram_sel;
  logic [7:0]                ram_data_in;
  logic                      new_data_req;
  logic [23:0]               rgb_data_out;
  logic                      send_leds_n;

  modport master (
    output addr_out, ram_sel, rgb_data_out, send_leds_n,
    input  ram_data_in, new_data_req
  );

  modport slave (
    input  addr_out, ram_sel, rgb_data_out, send_leds_n,
    output ram_data_in, new_data_req
  );
endinterface

// File: rtl/led_frame_streamer.sv
// led_frame_streamer
//   Walks the RAM bank as one linear byte space, packs every three bytes
//   into a {G,R,B} word and streams the words to the ws2812 encoder on the
//   new_data_req handshake, holding send_leds_n low for the whole frame.
//   Owns the RAM read port while busy is high.
//   Ports:
//     clk_sb    system bus clock, rising edge
//     reset_n   asynchronous active-low reset
//     start     one-cycle frame-start pulse (accepted only when idle)
//     num_leds  LED count, sampled on the start cycle, clamped to MAX_LEDS
//     busy      high from the accepted start until the done pulse
//     done      one-cycle pulse at frame end
//     bus       RAM read port + encoder handshake (master side)
module led_frame_streamer #(
  parameter int unsigned NUM_MEM_BLOCKS = 14,
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned LED_CNT_W      = 12
) (
  input  logic                 clk_sb,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LED_CNT_W-1:0] num_leds,
  output logic                 busy,
  output logic                 done,
  led_frame_streamer_if.master bus
);

  localparam int unsigned MAX_LEDS = (NUM_MEM_BLOCKS * (2 ** ADDR_W)) / 3;
  localparam int unsigned BLK_W    = (NUM_MEM_BLOCKS > 1) ? $clog2(NUM_MEM_BLOCKS) : 1;
  localparam int unsigned PTR_W    = ADDR_W + BLK_W;
  localparam logic [LED_CNT_W-1:0] MAX_LEDS_C = LED_CNT_W'(MAX_LEDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_t;

  // state and datapath registers
  state_t                    r_state;
  logic [PTR_W-1:0]          r_ptr;       // next byte to issue
  logic [1:0]                r_fcnt;      // cycle inside the 4-cycle fetch
  logic [7:0]                r_stage_g;
  logic [7:0]                r_stage_r;
  logic [LED_CNT_W-1:0]      r_n;
  logic [LED_CNT_W-1:0]      r_fetched;   // LEDs loaded into rgb_data_out
  logic                      r_pend;
  logic                      r_busy;
  logic                      r_done;
  logic [ADDR_W-1:0]         r_addr;
  logic [NUM_MEM_BLOCKS-1:0] r_sel;
  logic [23:0]               r_rgb;
  logic                      r_send_n;

  // next-state values
  state_t                    w_state_nxt;
  logic [PTR_W-1:0]          w_ptr_nxt;
  logic [1:0]                w_fcnt_nxt;
  logic [7:0]                w_stage_g_nxt;
  logic [7:0]                w_stage_r_nxt;
  logic [LED_CNT_W-1:0]      w_n_nxt;
  logic [LED_CNT_W-1:0]      w_fetched_nxt;
  logic                      w_pend_nxt;
  logic                      w_busy_nxt;
  logic                      w_done_nxt;
  logic [ADDR_W-1:0]         w_addr_nxt;
  logic [NUM_MEM_BLOCKS-1:0] w_sel_nxt;
  logic [23:0]               w_rgb_nxt;
  logic                      w_send_n_nxt;
  logic                      w_issue;
  logic [LED_CNT_W-1:0]      w_n_clamp;

  assign w_n_clamp = (num_leds > MAX_LEDS_C) ? MAX_LEDS_C : num_leds;

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_fcnt    <= '0;
      r_stage_g <= '0;
      r_stage_r <= '0;
      r_n       <= '0;
      r_fetched <= '0;
      r_pend    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_sel     <= '0;
      r_rgb     <= '0;
      r_send_n  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_stage_g <= w_stage_g_nxt;
      r_stage_r <= w_stage_r_nxt;
      r_n       <= w_n_nxt;
      r_fetched <= w_fetched_nxt;
      r_pend    <= w_pend_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_addr    <= w_addr_nxt;
      r_sel     <= w_sel_nxt;
      r_rgb     <= w_rgb_nxt;
      r_send_n  <= w_send_n_nxt;
    end
  end

  // addr_out/ram_sel are registered, so each read address is set up on the
  // edge that enters the cycle it is presented in. w_issue presents r_ptr
  // in the following cycle and advances the pointer.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_fcnt_nxt    = r_fcnt;
    w_stage_g_nxt = r_stage_g;
    w_stage_r_nxt = r_stage_r;
    w_n_nxt       = r_n;
    w_fetched_nxt = r_fetched;
    w_pend_nxt    = r_pend;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_addr_nxt    = r_addr;
    w_sel_nxt     = r_sel;
    w_rgb_nxt     = r_rgb;
    w_send_n_nxt  = r_send_n;
    w_issue       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_n_clamp == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_n_nxt       = w_n_clamp;
            w_fetched_nxt = '0;
            w_pend_nxt    = 1'b0;
            w_busy_nxt    = 1'b1;
            w_fcnt_nxt    = '0;
            // byte 0 is issued directly; r_ptr still holds the previous frame
            w_addr_nxt    = '0;
            w_sel_nxt     = NUM_MEM_BLOCKS'(1);
            w_ptr_nxt     = PTR_W'(1);
            w_state_nxt   = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (bus.new_data_req) begin
          w_pend_nxt = 1'b1;
        end
        w_fcnt_nxt = r_fcnt + 2'd1;
        case (r_fcnt)
          2'd0: begin
            w_issue = 1'b1;
          end
          2'd1: begin
            w_issue       = 1'b1;
            w_stage_g_nxt = bus.ram_data_in;
          end
          2'd2: begin
            w_sel_nxt     = '0;
            w_stage_r_nxt = bus.ram_data_in;
          end
          default: begin
            w_rgb_nxt     = {r_stage_g, r_stage_r, bus.ram_data_in};
            w_fetched_nxt = r_fetched + LED_CNT_W'(1);
            w_state_nxt   = (r_fetched == '0) ? S_PRIME : S_STREAM;
          end
        endcase
      end

      S_PRIME: begin
        w_send_n_nxt = 1'b0;
        w_state_nxt  = S_STREAM;
      end

      S_STREAM: begin
        if (bus.new_data_req || r_pend) begin
          w_pend_nxt = 1'b0;
          if (r_fetched < r_n) begin
            w_fcnt_nxt  = '0;
            w_issue     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end

      // The encoder already holds the final word; close the frame.
      S_DRAIN: begin
        w_send_n_nxt = 1'b1;
        w_done_nxt   = 1'b1;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = S_FIN;
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_issue) begin
      w_addr_nxt = r_ptr[ADDR_W-1:0];
      w_sel_nxt  = NUM_MEM_BLOCKS'(1) << r_ptr[PTR_W-1:ADDR_W];
      w_ptr_nxt  = r_ptr + PTR_W'(1);
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign bus.addr_out     = r_addr;
  assign bus.ram_sel      = r_sel;
  assign bus.rgb_data_out = r_rgb;
  assign bus.send_leds_n  = r_send_n;

endmodule

// File: tb/tb_led_frame_streamer.sv
// tb_led_frame_streamer
//   Bench for led_frame_streamer: a registered-read RAM bank model, a
//   directed encoder that pulses new_data_req, and a frame-level model
//   (expected words straight from the byte array, expected send_leds_n /
//   busy / done timing from the frame rules) compared on every cycle.
module tb_led_frame_streamer;
  localparam int NB     = 14;
  localparam int AW     = 9;
  localparam int LW     = 12;
  localparam int NBYTES = NB * 512;
  localparam int MAXL   = NBYTES / 3;

  logic          clk_sb   = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic [LW-1:0] num_leds = '0;
  logic          busy;
  logic          done;

  led_frame_streamer_if #(.NUM_MEM_BLOCKS(NB), .ADDR_W(AW)) bus ();

  led_frame_streamer #(
    .NUM_MEM_BLOCKS(NB),
    .ADDR_W(AW),
    .LED_CNT_W(LW)
  ) dut (
    .clk_sb(clk_sb),
    .reset_n(reset_n),
    .start(start),
    .num_leds(num_leds),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  always #5 clk_sb = ~clk_sb;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // RAM bank: one flat byte array, registered read through the one-hot select
  logic [7:0] mem [NBYTES];
  logic [7:0] ram_q = '0;
  always @(posedge clk_sb) begin
    for (int b = 0; b < NB; b++)
      if (bus.ram_sel[b]) ram_q <= mem[b * 512 + int'(bus.addr_out)];
  end
  assign bus.ram_data_in = ram_q;

  function automatic logic [23:0] word_of(input int k);
    return {mem[3 * k], mem[3 * k + 1], mem[3 * k + 2]};
  endfunction

  // frame model
  typedef struct {
    int unsigned   cyc;
    logic [NB-1:0] sel;
    logic [AW-1:0] addr;
  } sel_ev_t;

  sel_ev_t     sel_log[$];
  int unsigned cyc      = 0;
  int          done_cnt = 0;
  bit          m_inframe = 1'b0;
  bit          m_sn      = 1'b1;
  bit          m_done_now = 1'b0;
  int          m_n = 0, m_idx = 0, m_fall_cd = 0, m_rise_cd = 0;
  bit          c_done_was, c_inf_was, c_sn_was;
  int          c_n;

  always @(negedge clk_sb) begin
    cyc++;
    if (!reset_n) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_send_n", 32'(bus.send_leds_n), 1);
      chk("rst_sel", 32'(bus.ram_sel), 0);
      chk("rst_addr", 32'(bus.addr_out), 0);
      chk("rst_rgb", 32'(bus.rgb_data_out), 0);
      m_inframe  = 1'b0;
      m_sn       = 1'b1;
      m_done_now = 1'b0;
      m_fall_cd  = 0;
      m_rise_cd  = 0;
      m_idx      = 0;
      m_n        = 0;
    end else begin
      c_done_was = m_done_now;
      c_inf_was  = m_inframe;
      c_sn_was   = m_sn;
      chk("done", 32'(done), 32'(m_done_now));
      chk("busy", 32'(busy), 32'(m_inframe && !m_done_now));
      chk("send_leds_n", 32'(bus.send_leds_n), 32'(m_sn));
      chk("sel_onehot0", 32'($onehot0(bus.ram_sel)), 1);
      if (!m_inframe || m_done_now) chk("idle_sel", 32'(bus.ram_sel), 0);
      if (done) done_cnt++;
      if (bus.ram_sel != '0) sel_log.push_back('{cyc, bus.ram_sel, bus.addr_out});

      m_done_now = 1'b0;
      if (m_fall_cd > 0) begin
        m_fall_cd--;
        if (m_fall_cd == 0) m_sn = 1'b0;
      end
      if (m_rise_cd > 0) begin
        m_rise_cd--;
        if (m_rise_cd == 0) begin
          m_sn       = 1'b1;
          m_done_now = 1'b1;
        end
      end
      if (c_done_was) m_inframe = 1'b0;

      if (bus.new_data_req && !c_sn_was) begin
        chk("req_in_range", 32'(m_idx < m_n), 1);
        if (m_idx < m_n) chk($sformatf("word%0d", m_idx), 32'(bus.rgb_data_out), 32'(word_of(m_idx)));
        m_idx++;
        if (m_idx == m_n) m_rise_cd = 1;
      end

      if (start && !c_inf_was) begin
        c_n = (int'(num_leds) > MAXL) ? MAXL : int'(num_leds);
        if (c_n == 0) begin
          m_done_now = 1'b1;
        end else begin
          m_inframe = 1'b1;
          m_n       = c_n;
          m_idx     = 0;
          m_fall_cd = 5;
        end
      end
    end
  end

  // directed stimulus
  logic [23:0] got_words[$];

  task automatic tick();
    @(posedge clk_sb);
    #1;
  endtask

  task automatic start_frame(input int n);
    start    = 1'b1;
    num_leds = LW'(n);
    tick();
    start    = 1'b0;
    num_leds = '1;
  endtask

  // acts as the encoder: latch the word, request the next, wait 'gap' cycles
  task automatic encode(input int gap, input int max_words, output int nreq);
    int c;
    nreq = 0;
    c    = 0;
    while (bus.send_leds_n && c < 20) begin
      tick();
      c++;
    end
    chk("send_fall_wait", 32'(bus.send_leds_n), 0);
    while (!bus.send_leds_n && nreq < max_words) begin
      got_words.push_back(bus.rgb_data_out);
      bus.new_data_req = 1'b1;
      tick();
      bus.new_data_req = 1'b0;
      nreq++;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 40) begin
      tick();
      c++;
    end
    chk("busy_clear_wait", 32'(busy), 0);
    tick();
  endtask

  initial begin
    int nreq;
    int base;
    int d0;
    bus.new_data_req = 1'b0;
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'h00;

    // reset then idle
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_send_n", 32'(bus.send_leds_n), 1);
    chk("reset_sel", 32'(bus.ram_sel), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rgb", 32'(bus.rgb_data_out), 0);
    reset_n = 1'b1;
    repeat (100) tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rgb", 32'(bus.rgb_data_out), 0);

    // 2-LED frame with cycle-exact timing
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
    d0 = done_cnt;
    start_frame(2);
    repeat (3) tick();
    chk("rgb_start4", 32'(bus.rgb_data_out), 32'h000000);
    tick();
    chk("rgb_start5", 32'(bus.rgb_data_out), 32'h112233);
    chk("send_n_start5", 32'(bus.send_leds_n), 1);
    tick();
    chk("send_n_start6", 32'(bus.send_leds_n), 0);
    bus.new_data_req = 1'b1;
    tick();
    bus.new_data_req = 1'b0;
    repeat (3) tick();
    chk("rgb_req3", 32'(bus.rgb_data_out), 32'h112233);
    tick();
    chk("rgb_req4", 32'(bus.rgb_data_out), 32'h445566);
    bus.new_data_req = 1'b1;
    tick();
    bus.new_data_req = 1'b0;
    chk("drain_send_n", 32'(bus.send_leds_n), 0);
    tick();
    chk("fin_done", 32'(done), 1);
    chk("fin_busy", 32'(busy), 0);
    chk("fin_send_n", 32'(bus.send_leds_n), 1);
    tick();
    chk("fin_done_end", 32'(done), 0);
    chk("two_led_pulses", 32'(done_cnt - d0), 1);

    // block crossing on LED 170
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'(i * 37 + 5);
    mem[510] = 8'hAA; mem[511] = 8'hBB; mem[512] = 8'hCC;
    got_words.delete();
    base = sel_log.size();
    start_frame(171);
    encode(4, 5000, nreq);
    wait_idle();
    chk("xing_reqs", 32'(nreq), 171);
    chk("xing_word170", 32'(got_words[170]), 32'hAABBCC);
    chk("xing_sel510", 32'(sel_log[base + 510].sel), 32'h0001);
    chk("xing_sel511", 32'(sel_log[base + 511].sel), 32'h0001);
    chk("xing_sel512", 32'(sel_log[base + 512].sel), 32'h0002);
    chk("xing_addr512", 32'(sel_log[base + 512].addr), 0);
    chk("xing_consec", sel_log[base + 512].cyc - sel_log[base + 510].cyc, 2);

    // zero length
    d0   = done_cnt;
    base = sel_log.size();
    start_frame(0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    tick();
    chk("zero_done_end", 32'(done), 0);
    repeat (10) tick();
    chk("zero_pulses", 32'(done_cnt - d0), 1);
    chk("zero_no_reads", 32'(sel_log.size() - base), 0);

    // clamp to MAX_LEDS, second start mid-frame ignored
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom);
    d0 = done_cnt;
    got_words.delete();
    start_frame(4000);
    num_leds = LW'(5);
    tick();
    start    = 1'b1;
    num_leds = LW'(3);
    tick();
    start    = 1'b0;
    encode(4, 5000, nreq);
    wait_idle();
    chk("clamp_reqs", 32'(nreq), 2389);
    chk("clamp_pulses", 32'(done_cnt - d0), 1);

    // reset mid-frame, then a clean 1-LED frame
    d0 = done_cnt;
    start_frame(10);
    encode(4, 3, nreq);
    chk("mid_reqs", 32'(nreq), 3);
    chk("mid_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_send_n", 32'(bus.send_leds_n), 1);
    chk("async_busy", 32'(busy), 0);
    chk("async_sel", 32'(bus.ram_sel), 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("no_done_after_reset", 32'(done_cnt - d0), 0);
    mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h0F;
    got_words.delete();
    start_frame(1);
    encode(4, 5000, nreq);
    wait_idle();
    chk("post_reset_reqs", 32'(nreq), 1);
    chk("post_reset_word", 32'(got_words[0]), 32'h5AC30F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
